// File: rtl/positaccum_encode_16_es2.sv
// Posit encoder back end (es=2): rounds the raw accumulator value to nearest-even and packs it
// into an N-bit posit. Three-stage pipeline (decode, pack, round) that advances as a whole under
// valid/ready back-pressure, plus a saturating counter of saturated output beats.
module positaccum_encode_16_es2 #(
    parameter int unsigned N       = 32,
    parameter int unsigned SCALE_W = 8,
    parameter int unsigned FRAC_W  = 147,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SCALE_W+FRAC_W+2:0]    in_raw,
    input  logic                         in_trunc,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [N-1:0]                 out_posit,
    output logic                         out_inexact,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CNT_W-1:0]             sat_count,
    input  logic                         sat_clr
);

    localparam int unsigned RAW_W   = SCALE_W + FRAC_W + 3;
    // {terminator, e, fraction} followed by N zero bits so a full-length regime shift loses nothing
    localparam int unsigned V_W     = FRAC_W + 3 + N;
    localparam int          SAT_LIM = 4 * (int'(N) - 2);
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS = N'(1);
    localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

    // Field split of the raw input
    logic                      in_sgn;
    logic signed [SCALE_W-1:0] in_scale;
    logic signed [31:0]        in_scale_w;
    logic [FRAC_W-1:0]         in_frac;
    logic                      in_inf;
    logic                      in_zero;
    logic                      adv;

    assign in_sgn     = in_raw[RAW_W-1];
    assign in_scale   = $signed(in_raw[RAW_W-2 -: SCALE_W]);
    assign in_scale_w = 32'(in_scale);
    assign in_frac    = in_raw[FRAC_W+1:2];
    assign in_inf     = in_raw[1];
    assign in_zero    = in_raw[0];

    // The whole pipe moves together whenever the output register is free or being drained
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1 state
    logic                      s1_valid, s1_sgn, s1_inf, s1_zero, s1_trunc, s1_sat_hi, s1_sat_lo;
    logic signed [SCALE_W-1:0] s1_k;
    logic [1:0]                s1_e;
    logic [FRAC_W-1:0]         s1_frac;

    // S1: split scale into regime k and exponent e, flag out-of-range magnitudes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_trunc  <= 1'b0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
            s1_k      <= '0;
            s1_e      <= '0;
            s1_frac   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_sgn    <= in_sgn;
            s1_inf    <= in_inf;
            s1_zero   <= in_zero;
            s1_trunc  <= in_trunc;
            s1_sat_hi <= in_scale_w > SAT_LIM;
            s1_sat_lo <= in_scale_w < -SAT_LIM;
            s1_k      <= in_scale >>> 2;
            s1_e      <= in_scale[1:0];
            s1_frac   <= in_frac;
        end
    end

    // Stage 2 combinational pack
    logic               term;
    logic [SCALE_W-1:0] rlen;
    logic [V_W-1:0]     pk_src, pk_fill, pk_vec;

    // S2: shift {terminator, e, frac} right by the run length and fill the run with ~terminator
    always_comb begin
        term    = s1_k[SCALE_W-1];
        rlen    = term ? SCALE_W'(-s1_k) : SCALE_W'(s1_k + 1);
        pk_src  = {term, s1_e, s1_frac, {N{1'b0}}};
        pk_fill = term ? '0 : ~({V_W{1'b1}} >> rlen);
        pk_vec  = (pk_src >> rlen) | pk_fill;
    end

    logic         s2_valid, s2_sgn, s2_inf, s2_zero, s2_trunc, s2_sat_hi, s2_sat_lo;
    logic [N-2:0] s2_body;
    logic         s2_g, s2_s;

    // S2 register: top N-1 bits become the magnitude, then guard and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_sgn    <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_trunc  <= 1'b0;
            s2_sat_hi <= 1'b0;
            s2_sat_lo <= 1'b0;
            s2_body   <= '0;
            s2_g      <= 1'b0;
            s2_s      <= 1'b0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_sgn    <= s1_sgn;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
            s2_trunc  <= s1_trunc;
            s2_sat_hi <= s1_sat_hi;
            s2_sat_lo <= s1_sat_lo;
            s2_body   <= pk_vec[V_W-1 -: N-1];
            s2_g      <= pk_vec[V_W-N];
            s2_s      <= |pk_vec[V_W-N-1:0];
        end
    end

    logic         inc;
    logic [N-1:0] sum, mag, res;
    logic         res_inexact, res_sat;

    // S3: round to nearest-even, clamp away from zero/NaR, apply saturation, sign and specials
    always_comb begin
        inc         = s2_g & (s2_body[0] | s2_s);
        sum         = {1'b0, s2_body} + N'(inc);
        mag         = sum;
        res_sat     = 1'b0;
        res_inexact = s2_trunc | s2_g | s2_s;
        if (sum[N-1]) begin
            mag = MAXPOS;
        end else if (sum == '0) begin
            mag = MINPOS;
        end
        if (s2_sat_hi) begin
            mag     = MAXPOS;
            res_sat = 1'b1;
        end else if (s2_sat_lo) begin
            mag     = MINPOS;
            res_sat = 1'b1;
        end
        res = s2_sgn ? (~mag + N'(1)) : mag;
        if (s2_inf) begin
            res         = NAR;
            res_sat     = 1'b0;
            res_inexact = s2_trunc;
        end else if (s2_zero) begin
            res         = '0;
            res_sat     = 1'b0;
            res_inexact = s2_trunc;
        end
    end

    // S3 register: output beat, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_posit   <= '0;
            out_inexact <= 1'b0;
            out_sat     <= 1'b0;
        end else if (adv) begin
            out_valid   <= s2_valid;
            out_posit   <= res;
            out_inexact <= res_inexact;
            out_sat     <= res_sat;
        end
    end

    // Count transferred saturated beats, sticking at all-ones; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_positaccum_encode_16_es2.sv
// Directed bench for positaccum_encode_16_es2 with hand-computed posit values.
module tb_positaccum_encode_16_es2;

    localparam int unsigned N       = 32;
    localparam int unsigned SCALE_W = 8;
    localparam int unsigned FRAC_W  = 147;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned RAW_W   = SCALE_W + FRAC_W + 3;

    logic              clk;
    logic              rst_n;
    logic [RAW_W-1:0]  in_raw;
    logic              in_trunc;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      out_posit;
    logic              out_inexact;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  sat_count;
    logic              sat_clr;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    positaccum_encode_16_es2 #(
        .N       (N),
        .SCALE_W (SCALE_W),
        .FRAC_W  (FRAC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_raw      (in_raw),
        .in_trunc    (in_trunc),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_posit   (out_posit),
        .out_inexact (out_inexact),
        .out_sat     (out_sat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sat_count   (sat_count),
        .sat_clr     (sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RAW_W-1:0] mk(input logic sgn, input logic [7:0] scale,
                                            input logic [FRAC_W-1:0] frac, input logic inf,
                                            input logic zero);
        return {sgn, scale, frac, inf, zero};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One beat through an empty pipe with out_ready=1; starts and ends on a falling edge
    task automatic send(input string tag, input logic [RAW_W-1:0] raw, input logic trunc,
                        input logic [N-1:0] ep, input logic ei, input logic es,
                        input logic chk_inx, input logic clr);
        in_raw   = raw;
        in_trunc = trunc;
        in_valid = 1'b1;
        #1;
        check($sformatf("%s/in_ready", tag), 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s/latency", tag), 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s/valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s/posit", tag), out_posit, ep);
        check($sformatf("%s/sat", tag), 32'(out_sat), 32'(es));
        if (chk_inx) check($sformatf("%s/inexact", tag), 32'(out_inexact), 32'(ei));
        if (clr) exp_cnt = 0;
        else if (es && exp_cnt < 65535) exp_cnt++;
        sat_clr = clr;
        @(posedge clk);
        @(negedge clk);
        sat_clr = 1'b0;
        check($sformatf("%s/sat_count", tag), 32'(sat_count), 32'(exp_cnt));
        check($sformatf("%s/drained", tag), 32'(out_valid), 32'd0);
    endtask

    logic [FRAC_W-1:0] f0, fcarry, ftie, fodd, fpat;
    logic [RAW_W-1:0]  bp_raw [6];
    logic [N-1:0]      bp_exp [6];

    initial begin
        rst_n     = 1'b1;
        in_raw    = '0;
        in_trunc  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        f0        = '0;
        fcarry    = '0;
        fcarry[146:119] = '1;
        ftie      = '0;
        ftie[119] = 1'b1;
        fodd      = '0;
        fodd[120] = 1'b1;
        fodd[119] = 1'b1;
        fpat      = '0;
        fpat[146:100] = '1;
        fpat[3]   = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/out_posit", out_posit, 32'd0);
        check("rst/out_inexact", 32'(out_inexact), 32'd0);
        check("rst/out_sat", 32'(out_sat), 32'd0);
        check("rst/sat_count", 32'(sat_count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Normal values
        send("one",     mk(1'b0, 8'd0,   f0, 1'b0, 1'b0), 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("neg_one", mk(1'b1, 8'd0,   f0, 1'b0, 1'b0), 1'b0, 32'hC0000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("two",     mk(1'b0, 8'd1,   f0, 1'b0, 1'b0), 1'b0, 32'h48000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("half",    mk(1'b0, 8'hFF,  f0, 1'b0, 1'b0), 1'b0, 32'h38000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("sixteen", mk(1'b0, 8'd4,   f0, 1'b0, 1'b0), 1'b0, 32'h60000000, 1'b0, 1'b0, 1'b1, 1'b0);
        // Rounding
        send("rne_carry", mk(1'b0, 8'd0, fcarry, 1'b0, 1'b0), 1'b0, 32'h48000000, 1'b1, 1'b0, 1'b1, 1'b0);
        send("rne_tie_even", mk(1'b0, 8'd0, ftie, 1'b0, 1'b0), 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b1, 1'b0);
        send("rne_tie_odd", mk(1'b0, 8'd0, fodd, 1'b0, 1'b0), 1'b0, 32'h40000002, 1'b1, 1'b0, 1'b1, 1'b0);
        send("trunc_only", mk(1'b0, 8'd0, f0, 1'b0, 1'b0), 1'b1, 32'h40000000, 1'b1, 1'b0, 1'b1, 1'b0);
        // Saturation range edges
        send("edge_hi", mk(1'b0, 8'd120,  f0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send("edge_lo", mk(1'b0, 8'h88,   f0, 1'b0, 1'b0), 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
        send("sat_hi",  mk(1'b0, 8'd127,  f0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send("sat_lo",  mk(1'b0, 8'h80,   f0, 1'b0, 1'b0), 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
        send("sat_lo_neg", mk(1'b1, 8'h80, f0, 1'b0, 1'b0), 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send("sat_121", mk(1'b0, 8'd121,  f0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send("sat_m121", mk(1'b0, 8'h87,  f0, 1'b0, 1'b0), 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
        send("sat_clr", mk(1'b0, 8'd127,  f0, 1'b0, 1'b0), 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        // Specials
        send("inf",     mk(1'b0, 8'd5,  fpat, 1'b1, 1'b0), 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("inf_zero", mk(1'b1, 8'd127, fpat, 1'b1, 1'b1), 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0);
        send("zero",    mk(1'b0, 8'd127, fpat, 1'b0, 1'b1), 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
        send("zero_trunc", mk(1'b1, 8'd3, f0, 1'b0, 1'b1), 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Back-pressure stream: out_ready low for cycles 4..8
        bp_raw[0] = mk(1'b0, 8'd0,  f0, 1'b0, 1'b0); bp_exp[0] = 32'h40000000;
        bp_raw[1] = mk(1'b0, 8'd1,  f0, 1'b0, 1'b0); bp_exp[1] = 32'h48000000;
        bp_raw[2] = mk(1'b0, 8'hFF, f0, 1'b0, 1'b0); bp_exp[2] = 32'h38000000;
        bp_raw[3] = mk(1'b1, 8'd2,  f0, 1'b0, 1'b0); bp_exp[3] = 32'hB0000000;
        bp_raw[4] = mk(1'b0, 8'd3,  f0, 1'b0, 1'b0); bp_exp[4] = 32'h58000000;
        bp_raw[5] = mk(1'b0, 8'd4,  f0, 1'b0, 1'b0); bp_exp[5] = 32'h60000000;
        begin
            int  idx;
            int  rcv;
            bit  stalled;
            idx     = 0;
            rcv     = 0;
            stalled = 1'b0;
            for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
                out_ready = !(cyc >= 4 && cyc <= 8);
                in_valid  = (idx < 6);
                in_trunc  = 1'b0;
                if (idx < 6) in_raw = bp_raw[idx];
                #1;
                if (!in_ready) stalled = 1'b1;
                if (out_valid && out_ready) begin
                    check($sformatf("bp/beat%0d", rcv), out_posit, bp_exp[rcv]);
                    rcv++;
                end
                if (in_valid && in_ready) idx++;
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp/received", 32'(rcv), 32'd6);
            check("bp/sent", 32'(idx), 32'd6);
            check("bp/stalled", 32'(stalled), 32'd1);
            check("bp/empty", 32'(out_valid), 32'd0);
        end

        // Async reset with three beats in flight
        check("mid/pre_count", 32'(sat_count), 32'(exp_cnt));
        in_trunc = 1'b0;
        in_valid = 1'b1;
        in_raw   = mk(1'b0, 8'd127, f0, 1'b0, 1'b0);
        @(negedge clk);
        in_raw   = mk(1'b0, 8'd1, f0, 1'b0, 1'b0);
        @(negedge clk);
        in_raw   = mk(1'b0, 8'd2, f0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid/in_flight", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid/out_valid", 32'(out_valid), 32'd0);
        check("mid/out_posit", out_posit, 32'd0);
        check("mid/sat_count", 32'(sat_count), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid/flushed", 32'(out_valid), 32'd0);
        send("post_rst", mk(1'b0, 8'd1, f0, 1'b0, 1'b0), 1'b0, 32'h48000000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
